// File: rtl/clic_pkg.sv
// Shared definitions for the CLIC interrupt responder: privilege mode encodings
// and the responder FSM state type.
package clic_pkg;

  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DROP = 2'd2
  } clic_state_e;

endpackage

// File: rtl/clic_irq_eligible.sv
// Combinational eligibility check of one interrupt against the hart context.
// Zero latency, no state; reusable for per-mode threshold checks.
module clic_irq_eligible #(
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned ModeWidth = 2
) (
  input  logic [ModeWidth-1:0] mode,
  input  logic [PrioWidth-1:0] lvl,
  input  logic [ModeWidth-1:0] priv,
  input  logic                 mie,
  input  logic [PrioWidth-1:0] thresh,
  input  logic [PrioWidth-1:0] cur_lvl,
  output logic                 eligible
);

  logic [PrioWidth-1:0] floor_lvl;
  logic                 higher_mode;
  logic                 same_mode_wins;

  // Level must strictly exceed both the threshold and the level already being serviced.
  assign floor_lvl      = (thresh > cur_lvl) ? thresh : cur_lvl;
  assign higher_mode    = (mode > priv);
  assign same_mode_wins = (mode == priv) && mie && (lvl > floor_lvl);
  assign eligible       = higher_mode || same_mode_wins;

endmodule

// File: rtl/clic_irq_responder.sv
// Latches one CLIC offer and presents it to the core; ready/kill-ack are same-cycle pulses.
// Offer to core_irq_o is 1 cycle; the offer is held until taken, killed or withdrawn.
module clic_irq_responder
  import clic_pkg::*;
#(
  parameter int unsigned SrcWidth  = 8,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned ModeWidth = 2,
  parameter int unsigned VsidWidth = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 irq_valid_i,
  output logic                 irq_ready_o,
  input  logic [SrcWidth-1:0]  irq_id_i,
  input  logic [PrioWidth-1:0] irq_max_i,
  input  logic [ModeWidth-1:0] irq_mode_i,
  input  logic [VsidWidth-1:0] irq_vsid_i,
  input  logic                 irq_v_i,
  input  logic                 irq_shv_i,
  input  logic                 irq_kill_req_i,
  output logic                 irq_kill_ack_o,
  input  logic [ModeWidth-1:0] priv_i,
  input  logic                 mie_i,
  input  logic [PrioWidth-1:0] thresh_i,
  input  logic [PrioWidth-1:0] cur_lvl_i,
  input  logic                 core_take_i,
  output logic                 core_irq_o,
  output logic [SrcWidth-1:0]  core_id_o,
  output logic [PrioWidth-1:0] core_lvl_o,
  output logic [ModeWidth-1:0] core_mode_o,
  output logic [VsidWidth-1:0] core_vsid_o,
  output logic                 core_v_o,
  output logic                 core_shv_o
);

  clic_state_e          state_q;
  logic [SrcWidth-1:0]  id_q;
  logic [PrioWidth-1:0] lvl_q;
  logic [ModeWidth-1:0] mode_q;
  logic [VsidWidth-1:0] vsid_q;
  logic                 v_q;
  logic                 shv_q;

  logic eligible;
  logic in_pend;

  clic_irq_eligible #(
    .PrioWidth (PrioWidth),
    .ModeWidth (ModeWidth)
  ) u_eligible (
    .mode     (mode_q),
    .lvl      (lvl_q),
    .priv     (priv_i),
    .mie      (mie_i),
    .thresh   (thresh_i),
    .cur_lvl  (cur_lvl_i),
    .eligible (eligible)
  );

  // Handshake pulses are combinational so the CLIC sees them in the cycle the core commits.
  assign in_pend        = (state_q == ST_PEND);
  assign core_irq_o     = in_pend && eligible;
  assign irq_ready_o    = core_irq_o && core_take_i;
  assign irq_kill_ack_o = in_pend && irq_kill_req_i && !irq_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      lvl_q   <= '0;
      mode_q  <= '0;
      vsid_q  <= '0;
      v_q     <= 1'b0;
      shv_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (irq_valid_i) begin
            id_q    <= irq_id_i;
            lvl_q   <= irq_max_i;
            mode_q  <= irq_mode_i;
            vsid_q  <= irq_vsid_i;
            v_q     <= irq_v_i;
            shv_q   <= irq_shv_i;
            state_q <= ST_PEND;
          end
        end
        ST_PEND: begin
          // Take beats kill; a level source dropping valid abandons the offer quietly.
          if (irq_ready_o || irq_kill_ack_o) begin
            state_q <= ST_DROP;
          end else if (!irq_valid_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!irq_valid_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_id_o   = id_q;
  assign core_lvl_o  = lvl_q;
  assign core_mode_o = mode_q;
  assign core_vsid_o = vsid_q;
  assign core_v_o    = v_q;
  assign core_shv_o  = shv_q;

endmodule
